// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in, serial-out stage. Accepts a WIDTH-bit word over a
//             valid/ready handshake and emits it one bit per clock on sout.
//             Back-to-back words are sent with no idle cycle between them.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous, active-low reset
//             din        - parallel word, captured only on an accept edge
//             din_valid  - upstream offers a word on din
//             din_ready  - a word can be accepted this cycle
//             sout       - serial data (registered)
//             sout_valid - sout carries a payload bit (registered)
//             last       - sout is the final bit of the word (registered)
//             busy       - a word is being shifted out
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_sout_valid;
    logic             w_sout_valid_nxt;
    logic             r_last;
    logic             w_last_nxt;

    logic             w_at_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sr_shift;
    logic             w_first_bit;
    logic             w_next_bit;

    // The final bit of a word is on the line: a new word may be taken now,
    // replacing that bit at the next edge (zero-bubble reload).
    assign w_at_last = (r_state == S_SHIFT) && (r_cnt == C_CNT_LAST);
    // rst_n gates ready so nothing is offered to upstream during reset.
    assign din_ready = rst_n && ((r_state == S_IDLE) || w_at_last);
    assign w_accept  = din_valid && din_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // sr holds the word with the bit currently on the line at the outgoing
    // end; shifting exposes the next bit at that same end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shift  = r_sr << 1;
            assign w_first_bit = din[WIDTH-1];
            assign w_next_bit  = w_sr_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shift  = r_sr >> 1;
            assign w_first_bit = din[0];
            assign w_next_bit  = w_sr_shift[0];
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_sr_nxt         = r_sr;
        w_cnt_nxt        = r_cnt;
        w_sout_nxt       = r_sout;
        w_sout_valid_nxt = r_sout_valid;
        w_last_nxt       = r_last;

        if (w_accept) begin
            // Same load from IDLE and from the last-bit cycle of SHIFT.
            // WIDTH >= 2, so the first bit is never the last one.
            w_state_nxt      = S_SHIFT;
            w_sr_nxt         = din;
            w_cnt_nxt        = '0;
            w_sout_nxt       = w_first_bit;
            w_sout_valid_nxt = 1'b1;
            w_last_nxt       = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sout_nxt       = IDLE_LEVEL;
                    w_sout_valid_nxt = 1'b0;
                    w_last_nxt       = 1'b0;
                end
                S_SHIFT: begin
                    if (r_cnt != C_CNT_LAST) begin
                        w_sr_nxt         = w_sr_shift;
                        w_sout_nxt       = w_next_bit;
                        w_sout_valid_nxt = 1'b1;
                        w_cnt_nxt        = w_cnt_inc;
                        w_last_nxt       = (w_cnt_inc == C_CNT_LAST);
                    end else begin
                        w_state_nxt      = S_IDLE;
                        w_sout_nxt       = IDLE_LEVEL;
                        w_sout_valid_nxt = 1'b0;
                        w_last_nxt       = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt      = S_IDLE;
                    w_sout_nxt       = IDLE_LEVEL;
                    w_sout_valid_nxt = 1'b0;
                    w_last_nxt       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= w_sout_valid_nxt;
            r_last       <= w_last_nxt;
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign last       = r_last;
    assign busy       = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Self-checking bench for piso_serializer. Two instances share
//             the stimulus: LSB-first with idle level 0, and MSB-first with
//             idle level 1. A position-based reference model predicts every
//             output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_valid = 1'b0;

    logic rdy_a, sout_a, sv_a, last_a, busy_a;
    logic rdy_b, sout_b, sv_b, last_b, busy_b;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: index of the bit currently on the line, -1 when idle.
    int           m_pos  = -1;
    logic [W-1:0] m_word = '0;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_a),
        .sout       (sout_a),
        .sout_valid (sv_a),
        .last       (last_a),
        .busy       (busy_a)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_b),
        .sout       (sout_b),
        .sout_valid (sv_b),
        .last       (last_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return rst_n && ((m_pos < 0) || (m_pos == W - 1));
    endfunction

    task automatic check_outputs();
        logic ea, eb, ev, el;
        if (m_pos < 0) begin
            ea = 1'b0;
            eb = 1'b1;
        end else begin
            ea = m_word[m_pos];
            eb = m_word[W-1-m_pos];
        end
        ev = (m_pos >= 0);
        el = (m_pos == W - 1);
        check("sout_lsb",  32'(sout_a), 32'(ea));
        check("valid_lsb", 32'(sv_a),   32'(ev));
        check("last_lsb",  32'(last_a), 32'(el));
        check("busy_lsb",  32'(busy_a), 32'(ev));
        check("sout_msb",  32'(sout_b), 32'(eb));
        check("valid_msb", 32'(sv_b),   32'(ev));
        check("last_msb",  32'(last_b), 32'(el));
        check("busy_msb",  32'(busy_b), 32'(ev));
    endtask

    // One clock: drive inputs after a falling edge, check ready, advance the
    // model at the rising edge, check the registered outputs at the next
    // falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
        din_valid = v;
        din       = d;
        #1;
        check("ready_lsb", 32'(rdy_a), 32'(m_ready()));
        check("ready_msb", 32'(rdy_b), 32'(m_ready()));
        acc = v && m_ready();
        @(posedge clk);
        if (acc) begin
            m_word = d;
            m_pos  = 0;
        end else if (m_pos >= 0 && m_pos < W - 1) begin
            m_pos++;
        end else begin
            m_pos = -1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Upstream holds the word with valid high until it is accepted.
    task automatic push(input logic [W-1:0] word);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 2 * W + 2) begin
            cycle(1'b1, word, acc);
            n++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Idle cycles with din wandering, which must not disturb a word in flight.
    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), acc);
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        #1;
        m_pos = -1;
        check("areset_sout_lsb",  32'(sout_a), 32'd0);
        check("areset_valid_lsb", 32'(sv_a),   32'd0);
        check("areset_last_lsb",  32'(last_a), 32'd0);
        check("areset_busy_lsb",  32'(busy_a), 32'd0);
        check("areset_ready_lsb", 32'(rdy_a),  32'd0);
        check("areset_sout_msb",  32'(sout_b), 32'd1);
        check("areset_valid_msb", 32'(sv_b),   32'd0);
        check("areset_ready_msb", 32'(rdy_b),  32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready_lsb", 32'(rdy_a), 32'd0);
        check("reset_ready_msb", 32'(rdy_b), 32'd0);
        check_outputs();
        rst_n = 1'b1;

        // Single word: LSB instance sends 1,1,0,1; MSB instance sends 1,0,1,1.
        push(4'b1011);
        idle(3);
        // Back-to-back with valid held high: zero-gap A then 5.
        push(4'hA);
        push(4'h5);
        idle(2);
        // F is offered while 0 is in flight and taken on its last bit.
        push(4'h0);
        push(4'hF);
        idle(3);
        // Reset mid-word: no remaining bits after release.
        push(4'h9);
        idle(1);
        async_reset();
        idle(W + 1);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12) begin
                push(W'($urandom));
            end else if (r < 18) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                push(W'($urandom));
                idle(int'($urandom_range(0, W - 1)));
                async_reset();
            end
        end
        idle(W + 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
